// File: rtl/camera_stream_tx.sv
// camera_stream_tx: raster-timed RGB test-pattern source (camera emulator).
// Emits V_ACTIVE x H_ACTIVE frames with horizontal and vertical blanking.
// Every output is registered: the next-cycle output is derived from the
// next-state values of the raster counters.
// Optional feature macro: CAMERA_TX_GAP_EN inserts LFSR-driven pixel gaps
// inside active lines. The line stretches to absorb them.
module camera_stream_tx #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_BLANK  = 45
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        line_end,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned HTotal = H_ACTIVE + H_BLANK;
    localparam int unsigned VMax   = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    // Keep at least 8 h bits for the ramp and 4 v bits for the checker.
    localparam int unsigned HW     = ($clog2(HTotal) > 8) ? $clog2(HTotal) : 8;
    localparam int unsigned VW     = ($clog2(VMax) > 4) ? $clog2(VMax) : 4;
    localparam int unsigned BarW   = H_ACTIVE / 8;

    localparam logic [HW-1:0] HLastA = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HLastB = HW'(H_BLANK - 1);
    localparam logic [HW-1:0] HLastT = HW'(HTotal - 1);
    localparam logic [VW-1:0] VLastA = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VLastB = VW'(V_BLANK - 1);

    typedef enum logic [1:0] {StIdle, StActive, StHblank, StVblank} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [1:0]      pattern_q, pattern_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            gap_q, gap_d;

    logic [23:0]     pixel_data_d;
    logic            pixel_valid_d, frame_start_d, line_end_d, frame_done_d, busy_d;

    // Pixel colour for the selected pattern at raster position (h, v).
    function automatic logic [23:0] pattern_pixel(input logic [1:0]    sel,
                                                  input logic [HW-1:0] h,
                                                  input logic          v_bit3,
                                                  input logic [7:0]    fcnt);
        logic [HW-1:0] bar;
        logic [23:0]   pix;
        bar = h / HW'(BarW);
        pix = 24'h000000;
        unique case (sel)
            2'd0: begin
                case (bar)
                    HW'(0):  pix = 24'hFFFFFF;
                    HW'(1):  pix = 24'hFFFF00;
                    HW'(2):  pix = 24'h00FFFF;
                    HW'(3):  pix = 24'h00FF00;
                    HW'(4):  pix = 24'hFF00FF;
                    HW'(5):  pix = 24'hFF0000;
                    HW'(6):  pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            2'd1: pix = {h[7:0], h[7:0], h[7:0]};
            2'd2: pix = (h[3] ^ v_bit3) ? 24'hFFFFFF : 24'h000000;
            default: pix = {fcnt, ~fcnt, 8'h80};
        endcase
        return pix;
    endfunction

`ifdef CAMERA_TX_GAP_EN
    logic [15:0] lfsr_q, lfsr_d;

    // LFSR steps on every ACTIVE cycle; a zero low nibble marks the next cycle as a gap.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == StActive) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
        gap_d = (state_d == StActive) && (h_cnt_d != '0) && (lfsr_d[3:0] == 4'h0);
    end

    // LFSR and gap flag state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
            gap_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            gap_q  <= gap_d;
        end
    end
`else
    assign gap_d = 1'b0;
    assign gap_q = 1'b0;
`endif

    // Raster FSM next-state: counters, pattern latch and frame counter.
    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        pattern_d   = pattern_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StActive;
                    h_cnt_d   = '0;
                    v_cnt_d   = '0;
                    pattern_d = pattern_sel;
                end
            end
            StActive: begin
                // A gap cycle holds h so the pending pixel is emitted next.
                if (!gap_q) begin
                    if (h_cnt_q == HLastA) begin
                        state_d = StHblank;
                        h_cnt_d = '0;
                    end else begin
                        h_cnt_d = h_cnt_q + HW'(1);
                    end
                end
            end
            StHblank: begin
                if (h_cnt_q == HLastB) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == VLastA) begin
                        state_d = StVblank;
                        v_cnt_d = '0;
                    end else begin
                        state_d = StActive;
                        v_cnt_d = v_cnt_q + VW'(1);
                    end
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
            end
            StVblank: begin
                if (h_cnt_q == HLastT) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == VLastB) begin
                        v_cnt_d     = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        if (enable) begin
                            state_d   = StActive;
                            pattern_d = pattern_sel;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + VW'(1);
                    end
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next-cycle output values derived from the next raster position.
    always_comb begin
        pixel_valid_d = (state_d == StActive) && !gap_d;
        pixel_data_d  = 24'h000000;
        if (pixel_valid_d) begin
            pixel_data_d = pattern_pixel(pattern_d, h_cnt_d, v_cnt_d[3], frame_cnt_d);
        end
        frame_start_d = pixel_valid_d && (h_cnt_d == '0) && (v_cnt_d == '0);
        line_end_d    = pixel_valid_d && (h_cnt_d == HLastA);
        frame_done_d  = (state_d == StVblank) && (h_cnt_d == HLastT) && (v_cnt_d == VLastB);
        busy_d        = (state_d != StIdle);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            pattern_q   <= 2'd0;
            frame_cnt_q <= 8'h00;
            pixel_data  <= 24'h000000;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            pattern_q   <= pattern_d;
            frame_cnt_q <= frame_cnt_d;
            pixel_data  <= pixel_data_d;
            pixel_valid <= pixel_valid_d;
            frame_start <= frame_start_d;
            line_end    <= line_end_d;
            frame_done  <= frame_done_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_camera_stream_tx.sv
// Self-checking bench for camera_stream_tx (8x4 active, 4 hblank, 2 vblank lines).
// Expected pixels are queued per frame when a frame is requested and popped by
// a monitor on every valid output cycle.
module tb_camera_stream_tx;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VB = 2;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_start;
    logic        line_end;
    logic        frame_done;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [25:0] sb [$];

    camera_stream_tx #(
        .H_ACTIVE(HA),
        .H_BLANK (HB),
        .V_ACTIVE(VA),
        .V_BLANK (VB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .line_end   (line_end),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int sel, input int h, input int v,
                                            input int fid);
        logic [7:0] f8;
        logic [7:0] h8;
        f8 = fid[7:0];
        h8 = h[7:0];
        case (sel)
            0: begin
                case (h / (HA / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return {h8, h8, h8};
            2: return ((((h >> 3) ^ (v >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return {f8, ~f8, 8'h80};
        endcase
    endfunction

    // Queue one frame of expected {frame_start, line_end, pixel}.
    task automatic push_frame(input int sel, input int fid);
        for (int v = 0; v < VA; v++) begin
            for (int h = 0; h < HA; h++) begin
                sb.push_back({(h == 0 && v == 0), (h == HA - 1), exp_pix(sel, h, v, fid)});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = frame_start, 1 = frame_done. Expiry counts as a failed comparison.
    task automatic wait_for(input int which, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            hit = (which == 0) ? frame_start : frame_done;
        end
        check({tag, "_seen"}, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        sb.delete();
        check("reset_outputs",
              {3'b0, pixel_data, pixel_valid, frame_start, line_end, frame_done, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: every valid pixel pops one expectation; idle cycles must be zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pixel_valid) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    logic [25:0] e;
                    e = sb.pop_front();
                    check("pixel", {6'b0, frame_start, line_end, pixel_data}, {6'b0, e});
                end
            end else begin
                check("idle_zero", {6'b0, frame_start, line_end, pixel_data}, 32'd0);
            end
        end
    end

    initial begin
        int t0;
        int t1;
        rst_n       = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        #2;
        do_reset();

        // Colour bars, three back-to-back frames then a clean stop.
        pattern_sel = 2'd0;
        enable      = 1'b1;
        push_frame(0, 0);
        push_frame(0, 1);
        push_frame(0, 2);
        wait_for(0, 10, "first_frame_start");
        check("first_pixel", {8'h0, pixel_data}, 32'h00FFFFFF);
        check("first_busy", 32'(busy), 32'd1);
        wait_for(1, 200, "frame_done0");
        t0 = cyc;
        tick();
        check("start_after_done", 32'(frame_start), 32'd1);
        wait_for(1, 200, "frame_done1");
        t1 = cyc;
`ifndef CAMERA_TX_GAP_EN
        check("frame_period", 32'(t1 - t0), 32'd72);
`endif
        check("sb_after_two_frames", 32'(sb.size()), 32'(HA * VA));
        tick();
        enable = 1'b0;
        wait_for(1, 200, "frame_done2");
        check("busy_on_done", 32'(busy), 32'd1);
        tick();
        check("busy_fall", {30'b0, busy, pixel_valid}, 32'd0);
        repeat (5) tick();
        check("idle_stays", {7'b0, busy, pixel_data}, 32'd0);
        check("sb_empty_bars", 32'(sb.size()), 32'd0);

        // Frame id pattern over 257 frames; frame_cnt wraps back to 00.
        do_reset();
        pattern_sel = 2'd3;
        enable      = 1'b1;
        for (int f = 0; f < 257; f++) push_frame(3, f);
        for (int f = 0; f < 257; f++) begin
            wait_for(0, 200, "fid_frame_start");
            if (f == 0) check("fid_frame0", {8'h0, pixel_data}, 32'h0000FF80);
            if (f == 256) check("fid_frame256", {8'h0, pixel_data}, 32'h0000FF80);
            if (f == 5) begin
                // Mid-frame select change must not take effect.
                pattern_sel = 2'd1;
                repeat (20) tick();
                pattern_sel = 2'd3;
            end
        end
        // Drop enable during line 1 of the last frame.
        repeat (14) tick();
        enable = 1'b0;
        wait_for(1, 200, "drop_frame_done");
        check("drop_busy_on_done", 32'(busy), 32'd1);
        tick();
        check("drop_busy_fall", 32'(busy), 32'd0);
        repeat (4) tick();
        check("drop_idle_outputs",
              {3'b0, pixel_data, pixel_valid, frame_start, line_end, frame_done, busy}, 32'd0);
        check("sb_empty_fid", 32'(sb.size()), 32'd0);

        // Async reset in the middle of an active line.
        pattern_sel = 2'd0;
        enable      = 1'b1;
        push_frame(0, 0);
        wait_for(0, 10, "pre_reset_start");
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {30'b0, pixel_valid, busy}, 32'd0);
        sb.delete();
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {31'b0, busy}, 32'd0);

        // Checkerboard after reset.
        pattern_sel = 2'd2;
        enable      = 1'b1;
        push_frame(2, 0);
        wait_for(0, 10, "checker_start");
        tick();
        enable = 1'b0;
        wait_for(1, 200, "checker_done");
        tick();
        check("checker_busy_fall", 32'(busy), 32'd0);
        check("sb_empty_checker", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
